spi_slave_ram_gen: RTL and testbench
====================================

# spi_slave_ram_gen

Parametrised SPI slave with an embedded single-port register-file RAM. It is the next-generation replacement for the fixed 8-bit SPI slave/RAM top, with configurable data and address widths and memory depth. It adds frame-abort detection, out-of-range address handling and an optional address auto-increment burst mode. It sits directly behind the chip-level SPI pins; SPI timing is sampled on the system clock.

## Interface
- `DATA_WIDTH`, 8: RAM word width; also the frame payload width W.
- `ADDR_WIDTH`, 8: address register width; must be ≤ `DATA_WIDTH`; taken from payload bits [ADDR_WIDTH-1:0].
- `MEM_DEPTH`, 256: number of RAM words; must be ≤ 2^ADDR_WIDTH.

Ports:
- `clk` in 1: single clock; all sampling on rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `ss_n` in 1: slave select, active low.
- `mosi` in 1: serial data in, MSB first.
- `miso` out 1: serial data out, MSB first.
- `frame_err` out 1: one-cycle pulse on an aborted or malformed frame.
- `busy` out 1: high from frame start until the FSM returns to IDLE.

## Operation
- Frame format: 1 lead bit, then W+2 bits MSB first: cmd[1:0] followed by a W-bit payload.
  - Commands: 00 write address, 01 write data, 10 read address, 11 read data.
- FSM states:
  - IDLE: leaves when `ss_n`=0 is sampled. The `mosi` value at that edge is the lead bit: 0 goes to WRITE, 1 goes to READ.
  - WRITE / READ: shift W+2 bits.
    - If cmd[1] ≠ lead bit: pulse `frame_err`, no side effects, go to WAIT.
    - If cmd is 00 / 01 / 10: execute it, then go to WAIT.
    - If cmd is 11: go to XMIT.
  - XMIT: RAM read, then shift out W bits, then go to WAIT.
  - WAIT: ignores `mosi` until `ss_n`=1 is sampled, then goes to IDLE.
- Command effects:
  - 00: `wr_addr` ← payload[ADDR_WIDTH-1:0].
  - 01: `mem[wr_addr]` ← payload.
  - 10: `rd_addr` ← payload[ADDR_WIDTH-1:0].
  - 11: payload is ignored; transmits `mem[rd_addr]`.
- Out-of-range addresses (addr ≥ `MEM_DEPTH`):
  - Writes are dropped.
  - Reads transmit all zeros.
  - No error is flagged.
- Abort handling:
  - `ss_n`=1 sampled in WRITE or READ before the last frame bit: pulse `frame_err`, go to IDLE, no register or RAM change.
  - `ss_n`=1 in XMIT: stop transmitting, `miso`=0, go to IDLE, no error.
- Reset:
  - Effect: state IDLE; `wr_addr`=0, `rd_addr`=0, `miso`=0, `frame_err`=0, `busy`=0.
  - RAM contents are not reset and are preserved across reset.
  - Reset mid-frame discards the frame.
- A read-data command with no prior read-address command reads address 0.

## Timing
- Edge numbering: edge 0 is the first edge sampling `ss_n`=0, where the lead bit is captured. Frame bits are captured at edges 1..W+2.
- Write commands: the register or RAM update is visible at edge W+2.
- Read data:
  - RAM read is registered at edge W+3.
  - `miso` carries data bit W-1-k during the cycle after edge W+4+k, for k=0..W-1.
  - For W=8: bits appear after edges 12..19.
- `miso` is 0 whenever the FSM is not in XMIT.
- `frame_err` is high for exactly one cycle, in the cycle after the detecting edge.
- `busy` is registered: it rises after edge 0 and falls after the edge that returns the FSM to IDLE.
- Back-to-back frames need `ss_n` high for at least one sampled edge.

## Configuration
- `SPI_AUTO_INC_EN` defined:
  - After each executed 01 command, `wr_addr` increments.
  - After each completed 11 command, `rd_addr` increments.
  - Both wrap from `MEM_DEPTH-1` to 0.
  - A 11 command aborted in XMIT does not increment.
- `SPI_AUTO_INC_EN` undefined: addresses change only via 00 and 10 commands.

## Test plan
- Reset, write address 0x05 (frame 00_00000101), write data 0xA3 (01_10100011), read address 0x05 (10_00000101), read data -> `miso` shifts 1,0,1,0,0,0,1,1 after edges 12..19; `frame_err` stays 0.
- Raise `ss_n` after 5 bits of the frame 01_11110000 -> one-cycle `frame_err` pulse, FSM back in IDLE, the RAM word at `wr_addr` unchanged.
- Send lead bit 1 followed by cmd 01 -> `frame_err` pulse and no RAM write; a subsequent valid frame executes normally.
- With `MEM_DEPTH`=200: write address 0xF0, write data 0x5A, then read address 0xF0 and read data -> `miso` returns 0x00; `mem[0..199]` unchanged.
- `SPI_AUTO_INC_EN` defined: write address 0xFF, data 0x11, data 0x22; read address 0xFF, then two read-data frames -> reads return 0x11 then 0x22, showing the address wrapped to 0x00.
- Assert `rst` during XMIT of a read -> `miso`=0 and `busy`=0 immediately; a subsequent read of the same address returns the value written before reset.

Source files
------------

// File: rtl/spi_slave_ram_gen.sv
// SPI slave sampled on the system clock, fronting a single-port register-file RAM.
// Define SPI_AUTO_INC_EN to step the write/read addresses after each data transfer.
module spi_slave_ram_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_DEPTH  = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic ss_n,
    input  logic mosi,
    output logic miso,
    output logic frame_err,
    output logic busy
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W + 3);
    localparam int MW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [31:0]   DEPTH    = MEM_DEPTH;
    localparam logic [CW-1:0] LAST_BIT = CW'(W + 1);
    localparam logic [CW-1:0] TX_LAST  = CW'(W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_XMIT,
        S_WAIT
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [W:0]            shift_q, shift_d;
    logic [W-1:0]          txd_q, txd_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  miso_q, miso_d;
    logic                  err_q, err_d;
    logic                  busy_q, busy_d;

    logic [W-1:0] mem [MEM_DEPTH];
    logic         mem_we;
    logic [W+1:0] frame;
    logic [1:0]   cmd;
    logic [W-1:0] payload;
    logic         wr_in_range;
    logic         rd_in_range;
    logic [MW-1:0] wr_idx;
    logic [MW-1:0] rd_idx;

    // The last frame bit is still on mosi when the frame is decoded, so it is appended live.
    assign frame       = {shift_q, mosi};
    assign cmd         = frame[W+1:W];
    assign payload     = frame[W-1:0];
    assign wr_in_range = 32'(wr_addr_q) < DEPTH;
    assign rd_in_range = 32'(rd_addr_q) < DEPTH;
    assign wr_idx      = wr_addr_q[MW-1:0];
    assign rd_idx      = rd_addr_q[MW-1:0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        txd_d     = txd_q;
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        miso_d    = 1'b0;
        err_d     = 1'b0;
        mem_we    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!ss_n) begin
                    state_d = mosi ? S_READ : S_WRITE;
                    cnt_d   = '0;
                end
            end
            S_WRITE, S_READ: begin
                if (ss_n) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (cnt_q == LAST_BIT) begin
                    state_d = S_WAIT;
                    if (cmd[1] != (state_q == S_READ)) begin
                        err_d = 1'b1;
                    end else begin
                        case (cmd)
                            2'b00: wr_addr_d = payload[ADDR_WIDTH-1:0];
                            2'b01: begin
                                mem_we = wr_in_range;
`ifdef SPI_AUTO_INC_EN
                                wr_addr_d = (32'(wr_addr_q) == DEPTH - 32'd1) ? '0 : wr_addr_q + 1'b1;
`endif
                            end
                            2'b10: rd_addr_d = payload[ADDR_WIDTH-1:0];
                            default: begin
                                state_d = S_XMIT;
                                cnt_d   = '0;
                            end
                        endcase
                    end
                end else begin
                    shift_d = {shift_q[W-1:0], mosi};
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            S_XMIT: begin
                // First XMIT edge latches the word; the next W edges shift it out MSB first.
                if (ss_n) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    txd_d = rd_in_range ? mem[rd_idx] : '0;
                    cnt_d = CW'(1);
                end else if (cnt_q <= TX_LAST) begin
                    miso_d = txd_q[W-1];
                    txd_d  = txd_q << 1;
                    cnt_d  = cnt_q + CW'(1);
                end else begin
                    state_d = S_WAIT;
`ifdef SPI_AUTO_INC_EN
                    rd_addr_d = (32'(rd_addr_q) == DEPTH - 32'd1) ? '0 : rd_addr_q + 1'b1;
`endif
                end
            end
            S_WAIT: begin
                if (ss_n) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            txd_q     <= '0;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            miso_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
            miso_q    <= miso_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    // RAM contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_idx] <= payload;
        end
    end

    assign miso      = miso_q;
    assign frame_err = err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_spi_slave_ram_gen.sv
// Randomised bench for spi_slave_ram_gen: frame-level reference model plus per-cycle compare.
// Runs with MEM_DEPTH=200 so out-of-range addresses are exercised.
module tb_spi_slave_ram_gen;

    localparam int W     = 8;
    localparam int DEPTH = 200;

    logic clk = 1'b0;
    logic rst;
    logic ss_n;
    logic mosi;
    logic miso;
    logic frame_err;
    logic busy;

    spi_slave_ram_gen #(
        .DATA_WIDTH(W),
        .ADDR_WIDTH(8),
        .MEM_DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ss_n     (ss_n),
        .mosi     (mosi),
        .miso     (miso),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    logic [7:0] modelMem [DEPTH];
    logic [7:0] mWr;
    logic [7:0] mRd;
    bit         expMiso;
    bit         expErr;
    bit         expBusy;
    bit         checkEn;
    int         checks;
    int         errors;
    logic [7:0] rxBits;
    int         errSeen;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("miso", 32'(miso), 32'(expMiso));
            checkOutput("frame_err", 32'(frame_err), 32'(expErr));
            checkOutput("busy", 32'(busy), 32'(expBusy));
        end
    end

    function automatic logic [7:0] nextAddr(input logic [7:0] a);
        return (32'(a) == DEPTH - 1) ? 8'h00 : a + 8'h01;
    endfunction

    // One frame: stopEdge is the edge where ss_n=1 is sampled early (-1 = normal end),
    // rstAt is the edge after which reset is pulsed (-1 = none).
    task automatic applyStimulus(input bit lead, input logic [1:0] cmd, input logic [7:0] payload,
                                 input int stopEdge, input int rstAt);
        logic [9:0] frameBits;
        logic [7:0] d;
        bit         legal;
        bit         isRead;
        bit         frameAbort;
        int         sAt;
        int         endEdge;
        int         gap;
        frameBits = {cmd, payload};
        legal     = (cmd[1] == lead);
        isRead    = legal && (cmd == 2'b11);
        d         = (32'(mRd) < DEPTH) ? modelMem[mRd] : 8'h00;
        sAt       = stopEdge;
        if (sAt >= 1 && sAt <= (isRead ? 2*W+4 : W+2)) begin
            endEdge = sAt;
        end else begin
            sAt     = -1;
            endEdge = (isRead ? 2*W+5 : W+3) + $urandom_range(0, 2);
        end
        frameAbort = (sAt >= 1 && sAt <= W+2);
        rxBits     = '0;
        errSeen    = 0;
        for (int e = 0; e <= endEdge; e++) begin
            ss_n = (e == endEdge);
            if (e == 0)          mosi = lead;
            else if (e <= W+2)   mosi = frameBits[W+2-e];
            else                 mosi = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            expBusy = (e < endEdge);
            expErr  = (frameAbort && e == sAt) || (!legal && sAt < 0 && e == W+2);
            expMiso = isRead && !frameAbort && e >= W+4 && e <= 2*W+3 && e < endEdge && d[2*W+3-e];
            if (e >= W+4 && e <= 2*W+3) rxBits[2*W+3-e] = miso;
            if (frame_err) errSeen++;
            if (e == rstAt) begin
                #2;
                rst  = 1'b1;
                ss_n = 1'b1;
                #1;
                checkOutput("rst_miso", 32'(miso), 32'h0);
                checkOutput("rst_busy", 32'(busy), 32'h0);
                expMiso = 1'b0;
                expErr  = 1'b0;
                expBusy = 1'b0;
                mWr     = 8'h00;
                mRd     = 8'h00;
                @(posedge clk);
                #1;
                rst = 1'b0;
                return;
            end
        end
        if (legal && !frameAbort) begin
            case (cmd)
                2'b00: mWr = payload;
                2'b01: begin
                    if (32'(mWr) < DEPTH) modelMem[mWr] = payload;
`ifdef SPI_AUTO_INC_EN
                    mWr = nextAddr(mWr);
`endif
                end
                2'b10: mRd = payload;
                default: begin
`ifdef SPI_AUTO_INC_EN
                    if (sAt < 0) mRd = nextAddr(mRd);
`endif
                end
            endcase
        end
        gap = $urandom_range(0, 2);
        for (int i = 0; i < gap; i++) begin
            ss_n = 1'b1;
            mosi = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            expMiso = 1'b0;
            expErr  = 1'b0;
            expBusy = 1'b0;
        end
    endtask

    initial begin
        bit         lead;
        logic [1:0] cmd;
        int         stopAt;
        checks  = 0;
        errors  = 0;
        checkEn = 1'b0;
        expMiso = 1'b0;
        expErr  = 1'b0;
        expBusy = 1'b0;
        mWr     = 8'h00;
        mRd     = 8'h00;
        rst     = 1'b1;
        ss_n    = 1'b1;
        mosi    = 1'b0;
        #1;
        checkOutput("reset_miso", 32'(miso), 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        checkOutput("reset_err", 32'(frame_err), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst     = 1'b0;
        checkEn = 1'b1;

        // Give every in-range word a known value.
        for (int a = 0; a < DEPTH; a++) begin
            applyStimulus(1'b0, 2'b00, 8'(a), -1, -1);
            applyStimulus(1'b0, 2'b01, 8'($urandom), -1, -1);
        end

        applyStimulus(1'b0, 2'b00, 8'h05, -1, -1);
        applyStimulus(1'b0, 2'b01, 8'hA3, -1, -1);
        applyStimulus(1'b1, 2'b10, 8'h05, -1, -1);
        applyStimulus(1'b1, 2'b11, 8'h00, -1, -1);
        checkOutput("basic_read", 32'(rxBits), 32'hA3);
        checkOutput("basic_noerr", 32'(errSeen), 32'd0);

        applyStimulus(1'b0, 2'b01, 8'hF0, 6, -1);
        checkOutput("abort_errcnt", 32'(errSeen), 32'd1);
        applyStimulus(1'b1, 2'b11, 8'h00, -1, -1);
        checkOutput("abort_nowrite", 32'(rxBits), 32'hA3);

        applyStimulus(1'b1, 2'b01, 8'h77, -1, -1);
        checkOutput("lead_mismatch_err", 32'(errSeen), 32'd1);
        applyStimulus(1'b1, 2'b11, 8'h00, -1, -1);
        checkOutput("lead_mismatch_nowrite", 32'(rxBits), 32'hA3);

        applyStimulus(1'b0, 2'b00, 8'hF0, -1, -1);
        applyStimulus(1'b0, 2'b01, 8'h5A, -1, -1);
        applyStimulus(1'b1, 2'b10, 8'hF0, -1, -1);
        applyStimulus(1'b1, 2'b11, 8'h00, -1, -1);
        checkOutput("oor_read_zero", 32'(rxBits), 32'h00);

        for (int n = 0; n < 150; n++) begin
            cmd    = 2'($urandom_range(0, 3));
            lead   = ($urandom_range(0, 99) < 85) ? cmd[1] : ~cmd[1];
            stopAt = ($urandom_range(0, 99) < 15) ? int'($urandom_range(1, 2*W+4)) : -1;
            applyStimulus(lead, cmd, 8'($urandom), stopAt, -1);
        end

        applyStimulus(1'b0, 2'b00, 8'h21, -1, -1);
        applyStimulus(1'b0, 2'b01, 8'hC3, -1, -1);
        applyStimulus(1'b1, 2'b10, 8'h21, -1, -1);
        applyStimulus(1'b1, 2'b11, 8'h00, -1, W+5);
        applyStimulus(1'b1, 2'b11, 8'h00, -1, -1);
        applyStimulus(1'b1, 2'b10, 8'h21, -1, -1);
        applyStimulus(1'b1, 2'b11, 8'h00, -1, -1);
        checkOutput("after_reset_read", 32'(rxBits), 32'hC3);

        for (int a = 0; a < DEPTH; a++) begin
            applyStimulus(1'b1, 2'b10, 8'(a), -1, -1);
            applyStimulus(1'b1, 2'b11, 8'($urandom), -1, -1);
        end

        checkEn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
